// File: rtl/alu_mdu.sv
// Combinational ALU plus iterative multiply/divide unit with HI/LO registers.
// Define ALU_OVF_EN to add the combinational signed ADD/SUB overflow output.
module alu_mdu #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       conf,
    input  logic             sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
`ifdef ALU_OVF_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? ('0 - x) : x;
    endfunction

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;     // multiplier / dividend->quotient
    logic [WIDTH-1:0] b_q, b_d;     // multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d; // product high half / partial remainder
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum, diff;
    logic               slt;
    logic               launch;
    logic               sa, sb;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // ---------------- combinational ALU ----------------
    assign shamt = in1[SHW-1:0];
    assign sum   = in1 + in2;
    assign diff  = in1 - in2;
    assign slt   = sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

    always_comb begin
        result = '0;
        case (conf)
            5'd0:    result = sum;
            5'd1:    result = diff;
            5'd2:    result = in1 & in2;
            5'd3:    result = in1 | in2;
            5'd4:    result = in1 ^ in2;
            5'd5:    result = ~(in1 | in2);
            5'd6:    result = in2 << shamt;
            5'd7:    result = in2 >> shamt;
            5'd8:    result = $unsigned($signed(in2) >>> shamt);
            5'd9:    result = {{(WIDTH-1){1'b0}}, slt};
            5'd12:   result = hi_q;
            5'd13:   result = lo_q;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_OVF_EN
    always_comb begin
        overflow = 1'b0;
        if (sign && conf == 5'd0) begin
            overflow = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        end else if (sign && conf == 5'd1) begin
            overflow = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
        end
    end
`endif

    // ---------------- multiply / divide unit ----------------
    assign launch = start && (state_q == StIdle) && (conf == 5'd10 || conf == 5'd11);
    assign sa     = sign & in1[WIDTH-1];
    assign sb     = sign & in2[WIDTH-1];

    assign mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {acc_q, a_q[WIDTH-1]};
    // A set MSB means the trial subtraction borrowed: restore.
    assign div_trial = div_shift - {1'b0, b_q};
    assign prod      = {acc_q, a_q};
    assign prod_fix  = neg_lo_q ? ('0 - prod) : prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    a_d      = mag(in1, sign);
                    b_d      = mag(in2, sign);
                    acc_d    = '0;
                    is_div_d = (conf == 5'd11);
                    neg_lo_d = sa ^ sb;
                    neg_hi_d = sa;
                    done_d   = done_q;
                end else if (conf == 5'd14) begin
                    hi_d = in1;
                end else if (conf == 5'd15) begin
                    lo_d = in1;
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    if (!div_trial[WIDTH]) begin
                        acc_d = div_trial[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    a_d   = {mul_sum[0], a_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (is_div_q) begin
                    // Divide by zero leaves |dividend| in acc; re-signing restores in1.
                    hi_d = neg_hi_q ? ('0 - acc_q) : acc_q;
                    if (b_q == '0) begin
                        lo_d = '1;
                    end else begin
                        lo_d = neg_lo_q ? ('0 - a_q) : a_q;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed and random ALU/MDU checks against a
// plain-arithmetic reference model.
module tb_alu_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   conf;
    logic         sign;
    logic [W-1:0] in1, in2;
    logic         start;
    logic [W-1:0] result, hi, lo;
    logic         zero, busy, done;
`ifdef ALU_OVF_EN
    logic         overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .conf    (conf),
        .sign    (sign),
        .in1     (in1),
        .in2     (in2),
        .start   (start),
        .result  (result),
        .zero    (zero),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
`ifdef ALU_OVF_EN
        .overflow(overflow),
`endif
        .lo      (lo)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] alu_ref(input logic [4:0] c, input logic s,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0]   sh;
        logic [W-1:0] r;
        sh = a[4:0];
        case (c)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~(a | b);
            5'd6: r = b << sh;
            5'd7: r = b >> sh;
            5'd8: begin
                r = b >> sh;
                if (b[W-1]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            5'd9: r = s ? W'(longint'($signed(a)) < longint'($signed(b))) : W'(a < b);
            5'd12: r = exp_hi;
            5'd13: r = exp_lo;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic ovf_ref(input logic [4:0] c, input logic s,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        longint x;
        if (!s || c > 5'd1) return 1'b0;
        x = (c == 5'd0) ? longint'($signed(a)) + longint'($signed(b))
                        : longint'($signed(a)) - longint'($signed(b));
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // Returns {hi, lo}.
    function automatic logic [2*W-1:0] mdu_ref(input logic is_div, input logic s,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        if (!is_div) begin
            p = sa * sb;
            return p;
        end
        if (b == '0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
        return p;
    endfunction

    task automatic launch(input logic [4:0] c, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        conf  = c;
        sign  = s;
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        conf  = 5'd0;
        in1   = '0;
        in2   = '0;
    endtask

    // Counts cycles after the launch edge until done; a done held over from a
    // back-to-back launch is ignored on the first cycle.
    task automatic wait_done(input string tag);
        int k;
        int bc;
        bc = busy ? 1 : 0;
        k  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (busy) bc++;
            if (done && k > 1) break;
        end
        check({tag, " latency"}, W'(k), W'(33));
        check({tag, " busy cycles"}, W'(bc), W'(33));
    endtask

    task automatic mdu_op(input string tag, input logic is_div, input logic s,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] e;
        e = mdu_ref(is_div, s, a, b);
        launch(is_div ? 5'd11 : 5'd10, s, a, b);
        wait_done(tag);
        exp_hi = e[2*W-1:W];
        exp_lo = e[W-1:0];
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        conf = 5'd12;
        #1;
        check({tag, " mfhi"}, result, exp_hi);
        conf = 5'd13;
        #1;
        check({tag, " mflo"}, result, exp_lo);
        conf = 5'd0;
        tick();
        check({tag, " done cleared"}, W'(done), W'(0));
    endtask

    initial begin
        logic [2*W-1:0] e;
        logic [W-1:0]   ra, rb, old_hi, ref_r;
        logic [4:0]     rc;
        logic           rs;
        int             pulses;

        reset = 1'b0;
        conf  = 5'd0;
        sign  = 1'b0;
        in1   = '0;
        in2   = '0;
        start = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        #12;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Directed combinational cases.
        conf = 5'd8; in1 = 32'd4; in2 = 32'h8000_0000; #1;
        check("sra", result, 32'hF800_0000);
        conf = 5'd6; in1 = 32'd36; in2 = 32'd1; #1;
        check("sll shamt wrap", result, 32'h10);
        conf = 5'd9; sign = 1'b0; in1 = 32'hFFFF_FFFF; in2 = 32'd1; #1;
        check("sltu", result, 32'd0);
        sign = 1'b1; #1;
        check("slt signed", result, 32'd1);
        conf = 5'd1; in1 = 32'd5; in2 = 32'd5; #1;
        check("sub zero flag", W'(zero), W'(1));
`ifdef ALU_OVF_EN
        conf = 5'd0; sign = 1'b1; in1 = 32'h7FFF_FFFF; in2 = 32'd1; #1;
        check("add overflow", W'(overflow), W'(1));
        check("add wrap", result, 32'h8000_0000);
`endif

        // Random combinational ops (no HI/LO writes, no launches).
        for (int i = 0; i < 60; i++) begin
            rc   = 5'($urandom_range(0, 25));
            if (rc >= 5'd10) rc = rc + 5'd6;
            rs   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = (i % 4 == 0) ? ra : $urandom;
            conf = rc; sign = rs; in1 = ra; in2 = rb;
            #1;
            ref_r = alu_ref(rc, rs, ra, rb);
            check($sformatf("alu conf=%0d", rc), result, ref_r);
            check($sformatf("zero conf=%0d", rc), W'(zero), W'(ref_r == '0));
`ifdef ALU_OVF_EN
            check($sformatf("ovf conf=%0d", rc), W'(overflow), W'(ovf_ref(rc, rs, ra, rb)));
`endif
        end
        conf = 5'd0;
        sign = 1'b0;
        tick();

        // MTHI / MTLO.
        conf = 5'd14; in1 = 32'hCAFE_0001; tick();
        conf = 5'd15; in1 = 32'h0BAD_F00D; tick();
        conf = 5'd0;
        exp_hi = 32'hCAFE_0001;
        exp_lo = 32'h0BAD_F00D;
        check("mthi", hi, exp_hi);
        check("mtlo", lo, exp_lo);

        // Test-plan multiply and divides.
        mdu_op("smul", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
        check("smul plan hi", hi, 32'hFFFF_FFFF);
        check("smul plan lo", lo, 32'hFFFF_FFEB);
        mdu_op("udiv", 1'b1, 1'b0, 32'd100, 32'd7);
        check("udiv plan lo", lo, 32'd14);
        check("udiv plan hi", hi, 32'd2);
        mdu_op("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        check("sdiv plan lo", lo, 32'hFFFF_FFFD);
        check("sdiv plan hi", hi, 32'hFFFF_FFFF);
        mdu_op("sdiv ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("sdiv ovf lo", lo, 32'h8000_0000);
        check("sdiv ovf hi", hi, 32'd0);
        mdu_op("div0", 1'b1, 1'b0, 32'd5, 32'd0);
        check("div0 lo", lo, 32'hFFFF_FFFF);
        check("div0 hi", hi, 32'd5);
        mdu_op("sdiv0", 1'b1, 1'b1, 32'hFFFF_FF00, 32'd0);

        // Random multiply / divide.
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(1, 300)) : $urandom;
            if (i % 5 == 1) rb = ~rb;
            mdu_op($sformatf("rand%0d", i), 1'(i % 2), 1'($urandom_range(0, 1)), ra, rb);
        end

        // Interference while busy: ignored start, ignored MTHI, MFHI returns old hi.
        old_hi = exp_hi;
        e = mdu_ref(1'b0, 1'b1, 32'd123456, 32'hFFFF_FCEB);
        launch(5'd10, 1'b1, 32'd123456, 32'hFFFF_FCEB);
        pulses = 0;
        repeat (4) begin tick(); if (done) pulses++; end
        conf = 5'd11; sign = 1'b0; in1 = 32'd999; in2 = 32'd3; start = 1'b1;
        tick(); if (done) pulses++;
        start = 1'b0;
        conf = 5'd14; in1 = 32'h1234;
        tick(); if (done) pulses++;
        conf = 5'd12; #1;
        check("mfhi while busy", result, old_hi);
        check("busy mid-op", W'(busy), W'(1));
        conf = 5'd0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        exp_hi = e[2*W-1:W];
        exp_lo = e[W-1:0];
        check("busy ignore pulses", W'(pulses), W'(1));
        check("busy ignore hi", hi, exp_hi);
        check("busy ignore lo", lo, exp_lo);

        // Back-to-back: second launch in the done cycle.
        launch(5'd11, 1'b0, 32'd1000, 32'd33);
        wait_done("b2b first");
        check("b2b first lo", lo, 32'd30);
        check("b2b first hi", hi, 32'd10);
        e = mdu_ref(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        launch(5'd10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b second busy", W'(busy), W'(1));
        wait_done("b2b second");
        check("b2b second hi", hi, e[2*W-1:W]);
        check("b2b second lo", lo, e[W-1:0]);
        tick();

        // Reset mid-multiply.
        launch(5'd10, 1'b1, 32'h0001_2345, 32'h0000_0777);
        repeat (9) tick();
        reset = 1'b0;
        #1;
        check("abort busy", W'(busy), W'(0));
        check("abort hi", hi, '0);
        check("abort lo", lo, '0);
        check("abort done", W'(done), W'(0));
        #3;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort no done", W'(pulses), W'(0));
        check("abort hi stays", hi, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
